// File: rtl/scope_readout_pkg.sv
// Shared definitions for the capture-buffer readout engine: controller state
// encoding, the stream sync byte, header length and the bytes-per-word helper.
package scope_readout_pkg;

    // Readout controller states. HDR is only reachable when the header build
    // option is enabled; the encoding is kept stable across both builds.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        SEND  = 3'd4,
        FIN   = 3'd5,
        HOLD  = 3'd6,
        HDR   = 3'd7
    } state_t;

    // First header byte, lets the host find the start of a dump.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Number of header bytes sent ahead of the data when the header is enabled.
    localparam int HDR_BYTES = 4;

    // Bytes needed to carry one captured word; a partial top byte counts whole.
    function automatic int calc_nb(input int data_width);
        return (data_width + 7) / 8;
    endfunction

endpackage

// File: rtl/scope_readout_if.sv
// Bundle of the readout engine's buffer-read port, capture status and byte
// stream towards the UART transmitter. The master side is the readout engine,
// the slave side is its environment (capture buffer, capture control, UART).
interface scope_readout_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);

    logic                  i_stopped;
    logic [ADDR_WIDTH-1:0] i_waddr;
    logic [ADDR_WIDTH-1:0] o_raddr;
    logic                  o_ren;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic [7:0]            o_tx_data;
    logic                  o_tx_valid;
    logic                  i_tx_ready;
    logic                  o_busy;
    logic                  o_done;

    modport master (
        input  i_stopped,
        input  i_waddr,
        input  i_rdata,
        input  i_tx_ready,
        output o_raddr,
        output o_ren,
        output o_tx_data,
        output o_tx_valid,
        output o_busy,
        output o_done
    );

    modport slave (
        output i_stopped,
        output i_waddr,
        output i_rdata,
        output i_tx_ready,
        input  o_raddr,
        input  o_ren,
        input  o_tx_data,
        input  o_tx_valid,
        input  o_busy,
        input  o_done
    );

endinterface

// File: rtl/scope_word_serializer.sv
// Splits one captured word into bytes and presents them MSB byte first on a
// valid/ready stream. The word is zero-extended to a whole number of bytes,
// so a partial top byte carries zeros in its upper bits. o_last flags the
// cycle in which the final byte of the word is accepted.
module scope_word_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic                  i_abort,
    input  logic                  i_ready,
    output logic [7:0]            o_data,
    output logic                  o_valid,
    output logic                  o_last
);
    import scope_readout_pkg::*;

    localparam int NB = calc_nb(DATA_WIDTH);
    localparam int WW = NB * 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [WW-1:0] sreg_q, sreg_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic          fire;

    // Load a new word, step to the next byte on each handshake, or drop the
    // stream when the controller abandons the word part-way through.
    always_comb begin
        sreg_d  = sreg_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        fire    = valid_q & i_ready;
        if (i_load) begin
            sreg_d  = WW'(i_word);
            idx_d   = IW'(NB - 1);
            valid_d = 1'b1;
        end else if (i_abort) begin
            valid_d = 1'b0;
        end else if (fire) begin
            if (idx_q == '0) begin
                valid_d = 1'b0;
            end else begin
                idx_d  = idx_q - IW'(1);
                sreg_d = sreg_q << 8;
            end
        end
    end

    // Byte shift register, remaining-byte index and valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    // The top byte of the shift register is always the one on offer.
    always_comb begin
        o_data  = sreg_q[WW-1 -: 8];
        o_valid = valid_q;
        o_last  = valid_q & i_ready & (idx_q == '0);
    end

endmodule

// File: rtl/scope_readout.sv
// Readout engine for the logic-analyzer capture buffer. When capture stops it
// walks the circular buffer oldest entry first (starting at the writer's next
// write address) for 2^ADDR_WIDTH words and streams every word MSB byte first
// to the UART transmitter. Each buffer read takes a READ and a WAIT cycle, so
// words are separated by a two-cycle gap while bytes within a word can go out
// back to back. A dropped i_stopped abandons the dump without o_done; a dump
// that was in the middle of a byte first finishes that byte's handshake.
//
// Build option: define SCOPE_READOUT_HEADER_EN to prefix each dump with a
// 4-byte header (0xA5, DATA_WIDTH, ADDR_WIDTH, low start-address byte).
module scope_readout #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic            clk,
    input  logic            reset,
    scope_readout_if.master bus
);
    import scope_readout_pkg::*;

    localparam logic [ADDR_WIDTH:0]   LAST_COUNT = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;

    logic                  ser_load;
    logic                  ser_abort;
    logic                  ser_valid;
    logic                  ser_last;
    logic [7:0]            ser_data;

    logic                  hdr_active;
    logic [7:0]            hdr_byte;
    logic                  tx_valid;
    logic                  handshake;

    scope_word_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (ser_load),
        .i_word  (bus.i_rdata),
        .i_abort (ser_abort),
        .i_ready (bus.i_tx_ready),
        .o_data  (ser_data),
        .o_valid (ser_valid),
        .o_last  (ser_last)
    );

`ifdef SCOPE_READOUT_HEADER_EN
    localparam logic [7:0] HDR_LAST = 8'(HDR_BYTES - 1);
    localparam logic [7:0] DW_BYTE  = 8'(DATA_WIDTH);
    localparam logic [7:0] AW_BYTE  = 8'(ADDR_WIDTH);

    logic [7:0] hdr_idx_q, hdr_idx_d;

    // Select the header byte on offer while the controller sits in HDR.
    always_comb begin
        hdr_active = (state_q == HDR);
        case (hdr_idx_q)
            8'd0:    hdr_byte = SYNC_BYTE;
            8'd1:    hdr_byte = DW_BYTE;
            8'd2:    hdr_byte = AW_BYTE;
            default: hdr_byte = 8'(raddr_q);
        endcase
    end

    // Header byte position within the dump preamble.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_idx_q <= '0;
        end else begin
            hdr_idx_q <= hdr_idx_d;
        end
    end
`else
    // Without the header option the stream carries only serializer bytes.
    always_comb begin
        hdr_active = 1'b0;
        hdr_byte   = 8'h00;
    end
`endif

    // Merge header and data bytes onto the transmitter stream.
    always_comb begin
        tx_valid       = ser_valid | hdr_active;
        handshake      = tx_valid & bus.i_tx_ready;
        bus.o_tx_valid = tx_valid;
        bus.o_tx_data  = hdr_active ? hdr_byte : ser_data;
        bus.o_raddr    = raddr_q;
        bus.o_ren      = (state_q == READ);
        bus.o_busy     = (state_q == LATCH) || (state_q == READ) || (state_q == WAIT) ||
                         (state_q == SEND)  || (state_q == HDR);
        bus.o_done     = (state_q == FIN);
    end

    // Dump sequencing: latch the oldest address, then read/serialize each word
    // in turn, bailing out to IDLE as soon as the capture path restarts.
    always_comb begin
        state_d   = state_q;
        raddr_d   = raddr_q;
        count_d   = count_q;
        ser_load  = 1'b0;
        ser_abort = 1'b0;
`ifdef SCOPE_READOUT_HEADER_EN
        hdr_idx_d = hdr_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_stopped) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                raddr_d = bus.i_waddr;
                count_d = '0;
                if (!bus.i_stopped) begin
                    state_d = IDLE;
                end else begin
`ifdef SCOPE_READOUT_HEADER_EN
                    hdr_idx_d = '0;
                    state_d   = HDR;
`else
                    state_d   = READ;
`endif
                end
            end
            READ: begin
                state_d = bus.i_stopped ? WAIT : IDLE;
            end
            WAIT: begin
                if (!bus.i_stopped) begin
                    state_d = IDLE;
                end else begin
                    ser_load = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (ser_last) begin
                    raddr_d = raddr_q + ADDR_ONE;
                    count_d = count_q + COUNT_ONE;
                    if (!bus.i_stopped) begin
                        state_d = IDLE;
                    end else if (count_q == LAST_COUNT) begin
                        state_d = FIN;
                    end else begin
                        state_d = READ;
                    end
                end else if (handshake && !bus.i_stopped) begin
                    ser_abort = 1'b1;
                    state_d   = IDLE;
                end
            end
`ifdef SCOPE_READOUT_HEADER_EN
            HDR: begin
                if (handshake) begin
                    if (!bus.i_stopped) begin
                        state_d = IDLE;
                    end else if (hdr_idx_q == HDR_LAST) begin
                        state_d = READ;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 8'd1;
                    end
                end
            end
`endif
            FIN: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!bus.i_stopped) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state, read address and words-sent counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            raddr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            count_q <= count_d;
        end
    end

endmodule
